// File: rtl/bus_rw_arbiter.sv
// bus_rw_arbiter: round-robin arbiter and sequencer for two requesters sharing a tri-state register bus.
// Turnaround cycles keep the register and the master from driving the bus at the same time.
module bus_rw_arbiter #(
    parameter int WIDTH    = 8,
    parameter int TURN_CYC = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       req,
    input  logic [1:0]       we,
    input  logic [WIDTH-1:0] wdata_a,
    input  logic [WIDTH-1:0] wdata_b,
    output logic [1:0]       ack,
    output logic [WIDTH-1:0] rdata,
    output logic             busy,
    output logic             bus_rnw,
    output logic             bus_oe,
    output logic [WIDTH-1:0] bus_dout,
    input  logic [WIDTH-1:0] bus_din
);
    typedef enum logic [1:0] {IDLE, RD, TA, WR} state_t;

    state_t           state, state_nx;
    logic             g, g_nx, last, last_nx;
    logic [1:0]       cnt, cnt_nx, ack_nx, valid;
    logic [WIDTH-1:0] dout_nx, rdata_nx;

    // A requester is ignored while its own ack is high, so a held req counts as a new request only afterwards.
    assign valid = req & ~ack;

    always_comb begin
        state_nx = state;
        g_nx     = g;
        last_nx  = last;
        cnt_nx   = cnt;
        ack_nx   = '0;
        dout_nx  = bus_dout;
        rdata_nx = rdata;
        case (state)
            IDLE: if (|valid) begin
                g_nx     = (&valid) ? ~last : valid[1];
                last_nx  = g_nx;
                state_nx = we[g_nx] ? TA : RD;
                cnt_nx   = 2'(TURN_CYC - 1);
            end
            RD: begin
                rdata_nx  = bus_din;
                ack_nx[g] = 1'b1;
                state_nx  = IDLE;
            end
            TA: if (cnt == '0) begin
                state_nx = WR;
                dout_nx  = g ? wdata_b : wdata_a;
            end else begin
                cnt_nx = cnt - 2'd1;
            end
            WR: begin
                ack_nx[g] = 1'b1;
                // Chain a pending write from the other side so the register never drives between writes.
                if (valid[~g] && we[~g]) begin
                    g_nx    = ~g;
                    last_nx = ~g;
                    dout_nx = g ? wdata_a : wdata_b;
                end else begin
                    state_nx = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            g        <= 1'b0;
            last     <= 1'b1;
            cnt      <= '0;
            ack      <= '0;
            rdata    <= '0;
            busy     <= 1'b0;
            bus_rnw  <= 1'b1;
            bus_oe   <= 1'b0;
            bus_dout <= '0;
        end else begin
            state    <= state_nx;
            g        <= g_nx;
            last     <= last_nx;
            cnt      <= cnt_nx;
            ack      <= ack_nx;
            rdata    <= rdata_nx;
            busy     <= state_nx != IDLE;
            bus_rnw  <= !(state_nx == TA || state_nx == WR);
            bus_oe   <= state_nx == WR;
            bus_dout <= dout_nx;
        end
    end
endmodule

// File: tb/tb_bus_rw_arbiter.sv
// tb_bus_rw_arbiter: directed stimulus with a scoreboard of expected acks (requester, cycle, read data).
// Two instances: TURN_CYC=1 and TURN_CYC=3, each with a model of the shared register on its bus.
module tb_bus_rw_arbiter;
    typedef struct {
        logic       who;
        logic       rd;
        logic [7:0] data;
        int         cyc;
    } exp_t;

    logic       clk = 1'b0, rst_n = 1'b0, rd_only = 1'b0;
    logic [1:0] req1 = '0, we1 = '0, ack1, req3 = '0, we3 = '0, ack3;
    logic [7:0] wa1 = '0, wb1 = '0, rdata1, dout1, din1, reg1 = 8'h00;
    logic [7:0] wa3 = '0, wb3 = '0, rdata3, dout3, din3, reg3 = 8'h00;
    logic       busy1, rnw1, oe1, busy3, rnw3, oe3;
    int         total = 0, bad = 0, cyc = 0, k;
    exp_t       q1[$], q3[$], e1, e3;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bus_rw_arbiter #(.WIDTH(8), .TURN_CYC(1)) u1 (
        .clk(clk), .rst_n(rst_n), .req(req1), .we(we1), .wdata_a(wa1), .wdata_b(wb1),
        .ack(ack1), .rdata(rdata1), .busy(busy1), .bus_rnw(rnw1), .bus_oe(oe1),
        .bus_dout(dout1), .bus_din(din1));

    bus_rw_arbiter #(.WIDTH(8), .TURN_CYC(3)) u3 (
        .clk(clk), .rst_n(rst_n), .req(req3), .we(we3), .wdata_a(wa3), .wdata_b(wb3),
        .ack(ack3), .rdata(rdata3), .busy(busy3), .bus_rnw(rnw3), .bus_oe(oe3),
        .bus_dout(dout3), .bus_din(din3));

    // Register model: drives the bus when R_nW=1, captures the bus (0xEE when undriven) every clock when 0.
    assign din1 = rnw1 ? reg1 : (oe1 ? dout1 : 8'hEE);
    assign din3 = rnw3 ? reg3 : (oe3 ? dout3 : 8'hEE);
    always @(posedge clk) begin
        if (!rnw1) reg1 <= oe1 ? dout1 : 8'hEE;
        if (!rnw3) reg3 <= oe3 ? dout3 : 8'hEE;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        chk("u1_contention", {31'b0, oe1 & rnw1}, 32'd0);
        if (rd_only) chk("u1_read_only_bus", {30'b0, rnw1, oe1}, 32'b10);
        if (|ack1) begin
            if (q1.size() == 0) chk("u1_unexpected_ack", {30'b0, ack1}, 32'd0);
            else begin
                e1 = q1.pop_front();
                chk("u1_ack_who", {30'b0, ack1}, 32'd1 << e1.who);
                chk("u1_ack_cycle", cyc, e1.cyc);
                if (e1.rd) chk("u1_rdata", {24'b0, rdata1}, {24'b0, e1.data});
            end
        end
    end

    always @(negedge clk) begin
        chk("u3_contention", {31'b0, oe3 & rnw3}, 32'd0);
        if (|ack3) begin
            if (q3.size() == 0) chk("u3_unexpected_ack", {30'b0, ack3}, 32'd0);
            else begin
                e3 = q3.pop_front();
                chk("u3_ack_who", {30'b0, ack3}, 32'd1 << e3.who);
                chk("u3_ack_cycle", cyc, e3.cyc);
                if (e3.rd) chk("u3_rdata", {24'b0, rdata3}, {24'b0, e3.data});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        // Reset held with requests active.
        req1 = 2'b11; we1 = 2'b11; wa1 = 8'hFF; wb1 = 8'hFF; req3 = 2'b11; we3 = 2'b01;
        tick(3);
        chk("rst_u1_outputs", {rnw1, oe1, busy1, ack1, rdata1, dout1}, {1'b1, 1'b0, 1'b0, 2'b00, 8'h00, 8'h00});
        chk("rst_u3_outputs", {rnw3, oe3, busy3, ack3, rdata3, dout3}, {1'b1, 1'b0, 1'b0, 2'b00, 8'h00, 8'h00});
        req1 = '0; we1 = '0; req3 = '0; we3 = '0;
        rst_n = 1'b1;
        tick(3);
        chk("idle_after_reset", {rnw1, oe1, busy1, ack1}, {1'b1, 1'b0, 1'b0, 2'b00});

        // A writes 0x5A, then B reads it back.
        k = cyc; req1 = 2'b01; we1 = 2'b01; wa1 = 8'h5A;
        q1.push_back('{who: 1'b0, rd: 1'b0, data: 8'h00, cyc: k + 3});
        tick(1);
        chk("wr_ta_bus", {rnw1, oe1, busy1}, 3'b001);
        tick(1);
        chk("wr_drive_bus", {rnw1, oe1, dout1}, {2'b01, 8'h5A});
        tick(1);
        chk("wr_reg_5a", reg1, 8'h5A);
        req1 = '0;
        k = cyc; req1 = 2'b10; we1 = 2'b00;
        q1.push_back('{who: 1'b1, rd: 1'b1, data: 8'h5A, cyc: k + 2});
        tick(2);
        req1 = '0;
        tick(2);
        chk("t2_queue_empty", q1.size(), 0);

        // Both hold reads: acks alternate A,B,A,B every two cycles.
        k = cyc; req1 = 2'b11; we1 = 2'b00; rd_only = 1'b1;
        for (int i = 0; i < 4; i++)
            q1.push_back('{who: i[0], rd: 1'b1, data: 8'h5A, cyc: k + 2 + 2 * i});
        tick(8);
        req1 = '0;
        tick(2);
        rd_only = 1'b0;
        chk("t3_queue_empty", q1.size(), 0);

        // Simultaneous writes: one turnaround, then chained WR(0x11), WR(0x22).
        k = cyc; req1 = 2'b11; we1 = 2'b11; wa1 = 8'h11; wb1 = 8'h22;
        q1.push_back('{who: 1'b0, rd: 1'b0, data: 8'h00, cyc: k + 3});
        q1.push_back('{who: 1'b1, rd: 1'b0, data: 8'h00, cyc: k + 4});
        tick(1);
        chk("chain_ta", {rnw1, oe1}, 2'b00);
        tick(1);
        chk("chain_wr_a", {rnw1, oe1, dout1}, {2'b01, 8'h11});
        tick(1);
        chk("chain_wr_b", {rnw1, oe1, dout1}, {2'b01, 8'h22});
        req1 = 2'b10;
        tick(1);
        chk("chain_release", {rnw1, oe1, reg1}, {2'b10, 8'h22});
        req1 = '0;
        tick(2);
        chk("t4_queue_empty", q1.size(), 0);

        // TURN_CYC=3: three turnaround cycles before the write drives.
        k = cyc; req3 = 2'b01; we3 = 2'b01; wa3 = 8'hC3;
        q3.push_back('{who: 1'b0, rd: 1'b0, data: 8'h00, cyc: k + 5});
        for (int i = 0; i < 3; i++) begin
            tick(1);
            chk("t3cyc_ta", {rnw3, oe3}, 2'b00);
        end
        tick(1);
        chk("t3cyc_wr", {rnw3, oe3, dout3}, {2'b01, 8'hC3});
        tick(1);
        chk("t3cyc_reg", reg3, 8'hC3);
        req3 = '0;
        tick(2);
        chk("t5_queue_empty", q3.size(), 0);

        // Reset in the middle of WR drops the write; a later read still works.
        req1 = 2'b01; we1 = 2'b01; wa1 = 8'h77;
        tick(2);
        chk("mid_wr_driving", oe1, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("mid_wr_reset", {rnw1, oe1, busy1, ack1}, {1'b1, 1'b0, 1'b0, 2'b00});
        req1 = '0;
        tick(2);
        rst_n = 1'b1;
        tick(1);
        k = cyc; req1 = 2'b01; we1 = 2'b00;
        q1.push_back('{who: 1'b0, rd: 1'b1, data: 8'hEE, cyc: k + 2});
        tick(2);
        req1 = '0;
        tick(2);
        chk("t6_queue_empty", q1.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/bus_rw_arbiter.md
Name: bus_rw_arbiter

Overview:
- Two-requester arbiter and sequencer for the shared 8-bit tri-state register bus.
- Grants one requester at a time, round-robin.
- Drives the register's R_nW control: 1 = register drives the bus, 0 = register captures the bus every clock.
- Drives the master side of the bus, inserts turnaround cycles so the register and master never drive together, and returns read data with a one-cycle ack pulse.

Parameters:
- WIDTH, 8, data bus width.
- TURN_CYC, 1, cycles with both drivers off before a write drives the bus; legal 1..3.

Ports:
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- req  in  2  per-requester request level; [0]=A, [1]=B
- we  in  2  per-requester 1=write, 0=read; valid while req high
- wdata_a  in  WIDTH  A write data
- wdata_b  in  WIDTH  B write data
- ack  out  2  one-cycle completion pulse per requester
- rdata  out  WIDTH  read result, valid in the ack cycle, held until next read
- busy  out  1  high in any state other than IDLE
- bus_rnw  out  1  to register R_nW
- bus_oe  out  1  master drive enable for the bus
- bus_dout  out  WIDTH  master write data onto the bus
- bus_din  in  WIDTH  bus value (register read data)

Behaviour:
- All outputs are registered.
- Reset values: bus_rnw=1, bus_oe=0, bus_dout=0, ack=0, rdata=0, busy=0, state=IDLE, last_grant=B (so A wins first).
- Reset is async. Assertion mid-transaction forces reset values immediately: bus released, no ack issued, transaction dropped.
- Request rules:
  - Requester holds req, we and wdata stable until its ack.
  - req[i] is masked in any cycle where ack[i]=1.
  - A req still high after the ack cycle is a new request.
- Arbitration:
  - Only one requester valid: grant it.
  - Both valid: grant the one not equal to last_grant.
  - last_grant updates on each grant.
- States (bus_rnw / bus_oe per state):
  - IDLE (1/0): arbitrate. Granted read -> RD. Granted write -> TA with turn counter = TURN_CYC-1.
  - RD (1/0): at end of cycle, rdata<=bus_din and ack[g]<=1, then -> IDLE.
  - TA (0/0): register released. Garbage captured here is overwritten in WR. Counter decrements; at 0 -> WR with bus_dout<=wdata of the granted requester.
  - WR (0/1): register captures bus_dout at end of cycle; ack[g]<=1.
    - Other requester valid with we=1: chain to WR, last_grant updates, bus_dout<=its wdata, no TA.
    - Otherwise -> IDLE; bus_oe falls at the same edge bus_rnw rises.
- Back-to-back writes to the register are never split by a read-drive cycle.
- Latency, measured in cycles from the edge that first samples req to ack high:
  - Read: 2.
  - Write: 2+TURN_CYC.
  - Chained write: 1 after previous ack.
- After a write, a read by the other requester goes through IDLE. Data is therefore the newly written value.
- ack is never high for both requesters in the same cycle.
- busy=0 only in IDLE.

Test Plan:
1. Reset: hold rst_n=0, drive reqs -> bus_rnw=1, bus_oe=0, ack=0, rdata=0, busy=0. Release -> IDLE with no activity until req.
2. A writes 0x5A (TURN_CYC=1) -> bus_rnw=0 and bus_oe=0 for one cycle; then bus_oe=1 with bus_dout=0x5A; ack[0] three cycles after req sampled; register = 0x5A. Then B reads -> ack[1] two cycles later with rdata=0x5A.
3. A and B both hold read req continuously -> acks alternate A,B,A,B, one per 2 cycles. Bus_oe is never 1 and bus_rnw is never 0.
4. A writes 0x11 and B writes 0x22 simultaneously -> one TA cycle, WR(0x11), WR(0x22); bus_rnw low throughout; ack[0] then ack[1] on consecutive cycles; register = 0x22.
5. TURN_CYC=3, A writes 0xC3 -> three TA cycles with bus_oe=0; ack[0] at cycle 5; register = 0xC3.
6. Assert rst_n=0 during WR -> same cycle bus_oe=0 and bus_rnw=1, no ack pulse. After release, a new A read completes normally with 2-cycle latency.
